// File: rtl/cw305_pulpino_pkg.sv
// Shared types and constants for the CW305 -> PULPino command loader.
// Contents: FSM state enum, error bit indices, packed command width helper.
package cw305_pulpino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned ERR_TIMEOUT  = 0;
  localparam int unsigned ERR_OVERFLOW = 1;
  localparam int unsigned ERR_W        = 2;

  // Packed command layout is {we, be, addr, wdata}.
  function automatic int unsigned cmd_width(input int unsigned data_w, input int unsigned addr_w);
    return 1 + data_w / 8 + addr_w + data_w;
  endfunction

  localparam int unsigned CMD_W = cmd_width(32, 32);

endpackage

// File: rtl/cw305_loader_fifo.sv
// Synchronous FIFO holding packed loader commands.
// Ports: clk, reset (sync, active-high), push/din, pop, head_c (current head),
//        full_c/empty_c (decoded from the registered count), count.
// Pushes while full and pops while empty are ignored.
module cw305_loader_fifo #(
  parameter int unsigned pWIDTH = 8,
  parameter int unsigned pDEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [pWIDTH-1:0]             din,
  input  logic                          pop,
  output logic [pWIDTH-1:0]             head_c,
  output logic                          full_c,
  output logic                          empty_c,
  output logic [$clog2(pDEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(pDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [pWIDTH-1:0] mem [pDEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_en;
  logic              pop_en;

  assign full_c  = (count == CNT_W'(pDEPTH));
  assign empty_c = (count == '0);
  assign push_en = push & ~full_c;
  assign pop_en  = pop & ~empty_c;
  assign head_c  = mem[rd_ptr];

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

endmodule

// File: rtl/cw305_pulpino_loader.sv
// Bridge replaying buffered host read/write commands as PULPino req/gnt/rvalid
// bus transactions; returns read data, sticky errors and a completion count.
// Ports: crypto_clk/reset_i (sync, active-high); I_cmd_* command input with
//        O_cmd_ready; O_rdata/O_rdata_valid, O_busy, O_err/I_err_clr,
//        O_done_count status; data_* PULPino data port; O_trigger.
// Build option: CW305_PULPINO_LOADER_TRIGGER_EN drives O_trigger during writes;
//        otherwise O_trigger is tied low.
module cw305_pulpino_loader
  import cw305_pulpino_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pADDR_WIDTH = 32,
  parameter int unsigned pFIFO_DEPTH = 4,
  parameter int unsigned pTIMEOUT    = 255
) (
  input  logic                       crypto_clk,
  input  logic                       reset_i,
  input  logic                       I_cmd_valid,
  input  logic                       I_cmd_we,
  input  logic [pADDR_WIDTH-1:0]     I_cmd_addr,
  input  logic [pDATA_WIDTH-1:0]     I_cmd_wdata,
  input  logic [pDATA_WIDTH/8-1:0]   I_cmd_be,
  output logic                       O_cmd_ready,
  output logic [pDATA_WIDTH-1:0]     O_rdata,
  output logic                       O_rdata_valid,
  output logic                       O_busy,
  output logic [1:0]                 O_err,
  input  logic                       I_err_clr,
  output logic [15:0]                O_done_count,
  output logic                       data_req_o,
  output logic [pADDR_WIDTH-1:0]     data_addr_o,
  output logic                       data_we_o,
  output logic [pDATA_WIDTH/8-1:0]   data_be_o,
  output logic [pDATA_WIDTH-1:0]     data_wdata_o,
  input  logic                       data_gnt_i,
  input  logic                       data_rvalid_i,
  input  logic [pDATA_WIDTH-1:0]     data_rdata_i,
  output logic                       O_trigger
);

  localparam int unsigned BE_W  = pDATA_WIDTH / 8;
  localparam int unsigned CW    = cmd_width(pDATA_WIDTH, pADDR_WIDTH);
  localparam int unsigned OCC_W = $clog2(pFIFO_DEPTH) + 1;
  localparam int unsigned TMO_W = $clog2(pTIMEOUT + 1);
  // Counter starts at 0 on phase entry, so LAST is hit on cycle pTIMEOUT.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(pTIMEOUT - 1);

  state_t               state_q, state_d;
  logic [CW-1:0]        cmd_in, cmd_head;
  logic                 fifo_full, fifo_empty;
  logic [OCC_W-1:0]     fifo_count, occ_next;
  logic                 push_ok, pop;

  logic                 req_d, we_d, rvalid_d, busy_d;
  logic [pADDR_WIDTH-1:0] addr_d;
  logic [BE_W-1:0]      be_d;
  logic [pDATA_WIDTH-1:0] wdata_d, rdata_d;
  logic [15:0]          done_d;
  logic [TMO_W-1:0]     phase_cnt, cnt_d;
  logic [ERR_W-1:0]     err_set, err_d;

  assign cmd_in      = {I_cmd_we, I_cmd_be, I_cmd_addr, I_cmd_wdata};
  assign push_ok     = I_cmd_valid & ~fifo_full;
  assign O_cmd_ready = ~fifo_full;
  assign occ_next    = fifo_count + OCC_W'(push_ok) - OCC_W'(pop);

  cw305_loader_fifo #(
    .pWIDTH (CW),
    .pDEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .clk     (crypto_clk),
    .reset   (reset_i),
    .push    (push_ok),
    .din     (cmd_in),
    .pop     (pop),
    .head_c  (cmd_head),
    .full_c  (fifo_full),
    .empty_c (fifo_empty),
    .count   (fifo_count)
  );

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    req_d    = data_req_o;
    addr_d   = data_addr_o;
    we_d     = data_we_o;
    be_d     = data_be_o;
    wdata_d  = data_wdata_o;
    rdata_d  = O_rdata;
    rvalid_d = 1'b0;
    done_d   = O_done_count;
    cnt_d    = phase_cnt;
    pop      = 1'b0;
    err_set  = '0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          {we_d, be_d, addr_d, wdata_d} = cmd_head;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (data_gnt_i) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = RESP;
        end else if (phase_cnt == TMO_LAST) begin
          req_d                = 1'b0;
          err_set[ERR_TIMEOUT] = 1'b1;
          state_d              = IDLE;
        end else begin
          cnt_d = phase_cnt + TMO_W'(1);
        end
      end
      RESP: begin
        if (data_rvalid_i) begin
          if (!data_we_o) begin
            rdata_d  = data_rdata_i;
            rvalid_d = 1'b1;
          end
          done_d  = O_done_count + 16'd1;
          state_d = IDLE;
        end else if (phase_cnt == TMO_LAST) begin
          err_set[ERR_TIMEOUT] = 1'b1;
          state_d              = IDLE;
        end else begin
          cnt_d = phase_cnt + TMO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (I_cmd_valid && fifo_full) err_set[ERR_OVERFLOW] = 1'b1;

    // A new error event outranks a simultaneous clear.
    err_d  = (I_err_clr ? '0 : O_err) | err_set;
    busy_d = (occ_next != '0) || (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      state_q       <= IDLE;
      data_req_o    <= 1'b0;
      data_addr_o   <= '0;
      data_we_o     <= 1'b0;
      data_be_o     <= '0;
      data_wdata_o  <= '0;
      O_rdata       <= '0;
      O_rdata_valid <= 1'b0;
      O_done_count  <= '0;
      O_err         <= '0;
      O_busy        <= 1'b0;
      phase_cnt     <= '0;
    end else begin
      state_q       <= state_d;
      data_req_o    <= req_d;
      data_addr_o   <= addr_d;
      data_we_o     <= we_d;
      data_be_o     <= be_d;
      data_wdata_o  <= wdata_d;
      O_rdata       <= rdata_d;
      O_rdata_valid <= rvalid_d;
      O_done_count  <= done_d;
      O_err         <= err_d;
      O_busy        <= busy_d;
      phase_cnt     <= cnt_d;
    end
  end

`ifdef CW305_PULPINO_LOADER_TRIGGER_EN
  // Scope capture window: high while a write occupies REQ or RESP.
  always_ff @(posedge crypto_clk) begin
    if (reset_i) O_trigger <= 1'b0;
    else         O_trigger <= (state_d != IDLE) && we_d;
  end
`else
  assign O_trigger = 1'b0;
`endif

endmodule

// File: tb/tb_cw305_pulpino_loader.sv
// Directed self-checking bench for cw305_pulpino_loader.
module tb_cw305_pulpino_loader;

  logic        crypto_clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        I_cmd_valid = 1'b0;
  logic        I_cmd_we = 1'b0;
  logic [31:0] I_cmd_addr = '0;
  logic [31:0] I_cmd_wdata = '0;
  logic [3:0]  I_cmd_be = '0;
  logic        O_cmd_ready;
  logic [31:0] O_rdata;
  logic        O_rdata_valid;
  logic        O_busy;
  logic [1:0]  O_err;
  logic        I_err_clr = 1'b0;
  logic [15:0] O_done_count;
  logic        data_req_o;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i = 1'b0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic        O_trigger;

  int checks = 0;
  int errors = 0;

  cw305_pulpino_loader dut (
    .crypto_clk    (crypto_clk),
    .reset_i       (reset_i),
    .I_cmd_valid   (I_cmd_valid),
    .I_cmd_we      (I_cmd_we),
    .I_cmd_addr    (I_cmd_addr),
    .I_cmd_wdata   (I_cmd_wdata),
    .I_cmd_be      (I_cmd_be),
    .O_cmd_ready   (O_cmd_ready),
    .O_rdata       (O_rdata),
    .O_rdata_valid (O_rdata_valid),
    .O_busy        (O_busy),
    .O_err         (O_err),
    .I_err_clr     (I_err_clr),
    .O_done_count  (O_done_count),
    .data_req_o    (data_req_o),
    .data_addr_o   (data_addr_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_wdata_o  (data_wdata_o),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i),
    .O_trigger     (O_trigger)
  );

  always #5 crypto_clk = ~crypto_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge crypto_clk);
    #1;
  endtask

  task automatic set_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    I_cmd_valid = 1'b1;
    I_cmd_we    = we;
    I_cmd_addr  = addr;
    I_cmd_wdata = wd;
    I_cmd_be    = 4'hF;
  endtask

  // Wait for a request, check it, grant immediately, respond the next cycle.
  task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] wd);
    int n = 0;
    while (!data_req_o && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(data_req_o), 32'd1);
    check({tag, "_addr"}, data_addr_o, addr);
    check({tag, "_wdata"}, data_wdata_o, wd);
    check({tag, "_we"}, 32'(data_we_o), 32'd1);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b1;
    tick();
    data_rvalid_i = 1'b0;
  endtask

  // Full transaction with given grant/response delays; returns trigger-high cycles.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] rd,
                         input int gnt_dly, input int rv_dly, output int trig);
    trig = 0;
    set_cmd(we, addr, 32'h0);
    tick();
    I_cmd_valid = 1'b0;
    trig += int'(O_trigger);
    tick();
    for (int k = 0; k < gnt_dly; k++) begin
      trig += int'(O_trigger);
      tick();
    end
    trig += int'(O_trigger);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i = 1'b0;
    for (int k = 1; k < rv_dly; k++) begin
      trig += int'(O_trigger);
      tick();
    end
    trig += int'(O_trigger);
    data_rvalid_i = 1'b1;
    data_rdata_i  = rd;
    tick();
    data_rvalid_i = 1'b0;
    trig += int'(O_trigger);
    tick();
    trig += int'(O_trigger);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int trig;

    // Reset state
    tick();
    tick();
    reset_i = 1'b0;
    check("rst_ready", 32'(O_cmd_ready), 32'd1);
    check("rst_req", 32'(data_req_o), 32'd0);
    check("rst_busy", 32'(O_busy), 32'd0);
    check("rst_err", 32'(O_err), 32'd0);
    check("rst_done", 32'(O_done_count), 32'd0);
    check("rst_rdata", O_rdata, 32'd0);
    check("rst_trig", 32'(O_trigger), 32'd0);

    // Single write, gnt same cycle, rvalid next cycle
    set_cmd(1'b1, 32'h0000_1000, 32'hDEAD_BEEF);
    tick();
    I_cmd_valid = 1'b0;
    check("w1_req_n1", 32'(data_req_o), 32'd0);
    check("w1_busy_n1", 32'(O_busy), 32'd1);
    tick();
    check("w1_req_n2", 32'(data_req_o), 32'd1);
    check("w1_addr", data_addr_o, 32'h0000_1000);
    check("w1_wdata", data_wdata_o, 32'hDEAD_BEEF);
    check("w1_be", 32'(data_be_o), 32'hF);
    check("w1_we", 32'(data_we_o), 32'd1);
    data_gnt_i = 1'b1;
    tick();
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b1;
    check("w1_req_n3", 32'(data_req_o), 32'd0);
    tick();
    data_rvalid_i = 1'b0;
    check("w1_done", 32'(O_done_count), 32'd1);
    check("w1_no_rvalid", 32'(O_rdata_valid), 32'd0);
    check("w1_busy_n4", 32'(O_busy), 32'd0);

    // Read with 3-cycle gnt delay; stray rvalid during REQ must be ignored
    set_cmd(1'b0, 32'h0000_2000, 32'h0);
    tick();
    I_cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("r_req_held", 32'(data_req_o), 32'd1);
      check("r_addr_held", data_addr_o, 32'h0000_2000);
      if (i < 3) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = 32'h0000_0BAD;
      end else begin
        data_rvalid_i = 1'b0;
        data_gnt_i    = 1'b1;
      end
      tick();
    end
    data_gnt_i = 1'b0;
    check("r_req_drop", 32'(data_req_o), 32'd0);
    check("r_no_early_pulse", 32'(O_rdata_valid), 32'd0);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h1234_5678;
    tick();
    data_rvalid_i = 1'b0;
    check("r_pulse", 32'(O_rdata_valid), 32'd1);
    check("r_data", O_rdata, 32'h1234_5678);
    tick();
    check("r_pulse_end", 32'(O_rdata_valid), 32'd0);
    check("r_data_held", O_rdata, 32'h1234_5678);
    check("r_done", 32'(O_done_count), 32'd2);

    // Burst with gnt low: one command goes to the bus, four fill the FIFO
    for (int i = 0; i < 5; i++) begin
      check("b_ready", 32'(O_cmd_ready), 32'd1);
      set_cmd(1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      tick();
    end
    check("b_full_ready", 32'(O_cmd_ready), 32'd0);
    check("b_err_before", 32'(O_err), 32'd0);
    set_cmd(1'b1, 32'h200, 32'hBAD);
    tick();
    I_cmd_valid = 1'b0;
    check("b_overflow", 32'(O_err), 32'b10);
    for (int k = 0; k < 5; k++) serve("b_txn", 32'h100 + 32'(4 * k), 32'hA0 + 32'(k));
    check("b_done", 32'(O_done_count), 32'd7);
    check("b_idle_busy", 32'(O_busy), 32'd0);
    tick();
    tick();
    check("b_no_dropped_req", 32'(data_req_o), 32'd0);

    // Error clear, then timeout with a second command queued
    I_err_clr = 1'b1;
    tick();
    I_err_clr = 1'b0;
    check("clr_err", 32'(O_err), 32'd0);
    set_cmd(1'b0, 32'h3000, 32'h0);
    tick();
    set_cmd(1'b1, 32'h3004, 32'h55);
    tick();
    I_cmd_valid = 1'b0;
    n = 0;
    while (data_req_o && n < 400) begin
      n++;
      tick();
    end
    check("tmo_req_cycles", 32'(n), 32'd255);
    check("tmo_err", 32'(O_err), 32'b01);
    check("tmo_done", 32'(O_done_count), 32'd7);
    serve("tmo_next", 32'h3004, 32'h55);
    check("tmo_next_done", 32'(O_done_count), 32'd8);
    I_err_clr = 1'b1;
    tick();
    I_err_clr = 1'b0;
    check("tmo_clr", 32'(O_err), 32'd0);

    // Reset during RESP with two commands queued
    set_cmd(1'b0, 32'h4000, 32'h0);
    tick();
    set_cmd(1'b1, 32'h4004, 32'h44);
    tick();
    set_cmd(1'b1, 32'h4008, 32'h48);
    check("rr_req", 32'(data_req_o), 32'd1);
    data_gnt_i = 1'b1;
    tick();
    I_cmd_valid = 1'b0;
    data_gnt_i  = 1'b0;
    check("rr_in_resp", 32'(data_req_o), 32'd0);
    check("rr_busy", 32'(O_busy), 32'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("rr_req_after", 32'(data_req_o), 32'd0);
    check("rr_busy_after", 32'(O_busy), 32'd0);
    check("rr_ready_after", 32'(O_cmd_ready), 32'd1);
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hFFFF_FFFF;
    tick();
    data_rvalid_i = 1'b0;
    check("rr_late_rvalid", 32'(O_rdata_valid), 32'd0);
    check("rr_rdata", O_rdata, 32'd0);
    check("rr_done", 32'(O_done_count), 32'd0);
    tick();
    tick();
    check("rr_flushed_req", 32'(data_req_o), 32'd0);
    check("rr_flushed_busy", 32'(O_busy), 32'd0);

    // Trigger window: write with gnt delay 2 / rvalid delay 1, then a read
    run_txn(1'b1, 32'h5000, 32'h0, 2, 1, trig);
`ifdef CW305_PULPINO_LOADER_TRIGGER_EN
    check("trig_write", 32'(trig), 32'd4);
`else
    check("trig_write", 32'(trig), 32'd0);
`endif
    check("trig_write_done", 32'(O_done_count), 32'd1);
    run_txn(1'b0, 32'h5004, 32'hCAFE_F00D, 2, 1, trig);
    check("trig_read", 32'(trig), 32'd0);
    check("trig_read_data", O_rdata, 32'hCAFE_F00D);
    check("trig_read_done", 32'(O_done_count), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
